// File: rtl/debug_master_if.sv
// Command/response handshake between a host and debug_master.
// The host drives the master modport; debug_master uses the slave modport.
interface debug_master_if;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       resp_timeout;

  modport master (
    output cmd_valid, cmd_data,
    input  cmd_ready, resp_valid, resp_data, resp_timeout
  );

  modport slave (
    input  cmd_valid, cmd_data,
    output cmd_ready, resp_valid, resp_data, resp_timeout
  );
endinterface

// File: rtl/debug_master.sv
// Serial debug master: shifts one command byte to a target, then collects a response.
// Optional macro DEBUG_MASTER_TIMEOUT_EN gives up after TimeoutBytes all-zero filler bytes.
module debug_master #(
  parameter int ClkDiv       = 2,
  parameter int RespLen      = 2,
  parameter int TimeoutBytes = 16
) (
  input  logic          clk,
  input  logic          rst,
  debug_master_if.slave bus,
  output logic          debug_clk,
  output logic          debug_cs,
  output logic          debug_di,
  input  logic          debug_do
);

`ifdef DEBUG_MASTER_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  localparam logic [7:0] DivLast  = 8'(ClkDiv - 1);
  localparam logic [3:0] RespLast = 4'(RespLen - 1);
  localparam logic [7:0] ToLast   = 8'(TimeoutBytes - 1);
  localparam logic [8:0] GapLast  = 9'(2 * ClkDiv - 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WAIT, S_RESP, S_GAP} state_t;

  state_t     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic [3:0] rcnt_q, rcnt_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic [8:0] gap_q, gap_d;
  logic       sclk_q, sclk_d;
  logic       cs_q, cs_d;
  logic       di_q, di_d;
  logic       ready_q, ready_d;
  logic       want_q, want_d;
  logic       rv_q, rv_d;
  logic       rto_q, rto_d;
  logic [7:0] rdata_q, rdata_d;
  logic [6:0] cmd_q, cmd_d;
  logic [6:0] shin_q, shin_d;

  logic       tick;
  logic       fall;
  logic       go_gap;
  logic [7:0] rx_byte;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    rcnt_d  = rcnt_q;
    tcnt_d  = tcnt_q;
    gap_d   = gap_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    di_d    = di_q;
    ready_d = ready_q;
    want_d  = want_q;
    rv_d    = 1'b0;
    rto_d   = 1'b0;
    rdata_d = rdata_q;
    cmd_d   = cmd_q;
    shin_d  = shin_q;
    tick    = (div_q == DivLast);
    fall    = tick && sclk_q;
    rx_byte = {shin_q, debug_do};
    go_gap  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (bus.cmd_valid) begin
          state_d = S_CMD;
          ready_d = 1'b0;
          cs_d    = 1'b1;
          sclk_d  = 1'b0;
          div_d   = 8'd0;
          bit_d   = 3'd0;
          di_d    = bus.cmd_data[7];
          want_d  = bus.cmd_data[7];
          cmd_d   = bus.cmd_data[6:0];
        end
      end

      S_CMD, S_WAIT, S_RESP: begin
        div_d = tick ? 8'd0 : div_q + 8'd1;
        if (tick) sclk_d = ~sclk_q;
        // All work happens on debug_clk falling edges; rising edges belong to the target.
        if (fall) begin
          bit_d = bit_q + 3'd1;
          if (state_q == S_CMD) begin
            di_d  = cmd_q[6];
            cmd_d = {cmd_q[5:0], 1'b0};
            if (bit_q == 3'd7) begin
              di_d   = 1'b0;
              tcnt_d = 8'd0;
              if (want_q) state_d = S_WAIT;
              else        go_gap  = 1'b1;
            end
          end else begin
            shin_d = rx_byte[6:0];
            if (bit_q == 3'd7) begin
              if (state_q == S_RESP) begin
                rv_d    = 1'b1;
                rdata_d = rx_byte;
                rcnt_d  = rcnt_q + 4'd1;
                if (rcnt_q == RespLast) go_gap = 1'b1;
              end else if (rx_byte != 8'h00) begin
                rv_d    = 1'b1;
                rdata_d = rx_byte;
                rcnt_d  = 4'd1;
                if (RespLen == 1) go_gap  = 1'b1;
                else              state_d = S_RESP;
              end else begin
                tcnt_d = tcnt_q + 8'd1;
                if (TimeoutEn && (tcnt_q == ToLast)) begin
                  rto_d  = 1'b1;
                  go_gap = 1'b1;
                end
              end
            end
          end
        end
      end

      S_GAP: begin
        gap_d = gap_q + 9'd1;
        if (gap_q == GapLast) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Select drops together with the final falling edge of the transaction.
    if (go_gap) begin
      state_d = S_GAP;
      cs_d    = 1'b0;
      sclk_d  = 1'b0;
      di_d    = 1'b0;
      div_d   = 8'd0;
      gap_d   = 9'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= 8'd0;
      bit_q   <= 3'd0;
      rcnt_q  <= 4'd0;
      tcnt_q  <= 8'd0;
      gap_q   <= 9'd0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b0;
      di_q    <= 1'b0;
      ready_q <= 1'b1;
      want_q  <= 1'b0;
      rv_q    <= 1'b0;
      rto_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      rcnt_q  <= rcnt_d;
      tcnt_q  <= tcnt_d;
      gap_q   <= gap_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      di_q    <= di_d;
      ready_q <= ready_d;
      want_q  <= want_d;
      rv_q    <= rv_d;
      rto_q   <= rto_d;
      rdata_q <= rdata_d;
    end
  end

  // Shift registers carry no control meaning and need no reset.
  always_ff @(posedge clk) begin
    cmd_q  <= cmd_d;
    shin_q <= shin_d;
  end

  assign bus.cmd_ready    = ready_q;
  assign bus.resp_valid   = rv_q;
  assign bus.resp_data    = rdata_q;
  assign bus.resp_timeout = rto_q;
  assign debug_clk        = sclk_q;
  assign debug_cs         = cs_q;
  assign debug_di         = di_q;

endmodule

// File: tb/tb_debug_master.sv
// Scoreboard bench for debug_master: a target model answers each command and a
// reference model predicts responses, transaction length and LED state.
module tb_debug_master;
  localparam int CD = 2;
  localparam int RL = 2;
`ifdef DEBUG_MASTER_TIMEOUT_EN
  localparam int TB    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TB    = 16;
  localparam bit TO_EN = 1'b0;
`endif
  localparam int T = 10;

  typedef struct {
    int              delay;
    logic [3:0][7:0] r;
    bit              silent;
  } plan_t;

  typedef struct {
    bit         is_to;
    logic [7:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic debug_clk, debug_cs, debug_di, debug_do;

  debug_master_if bus();

  debug_master #(.ClkDiv(CD), .RespLen(RL), .TimeoutBytes(TB)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .debug_clk (debug_clk),
    .debug_cs  (debug_cs),
    .debug_di  (debug_di),
    .debug_do  (debug_do)
  );

  always #(T/2) clk = ~clk;

  int         n_chk  = 0;
  int         n_fail = 0;
  plan_t      plan_q[$];
  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] last_rx;
  logic       led;
  time        t_rise0, t_rise1, acc_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] tbyte(plan_t p, int i);
    if (p.silent || i < p.delay || i >= p.delay + 4) return 8'h00;
    return p.r[i - p.delay];
  endfunction

  function automatic int first_nz(plan_t p);
    for (int i = 0; i < p.delay + 4; i++)
      if (tbyte(p, i) != 8'h00) return i;
    return -1;
  endfunction

  function automatic bit times_out(plan_t p);
    int f = first_nz(p);
    return (f < 0) || (TO_EN && f >= TB);
  endfunction

  // Cycles from the accepting edge until cmd_ready is seen high again.
  function automatic int dur(logic [7:0] c, plan_t p);
    int nb;
    if (!c[7])             nb = 0;
    else if (times_out(p)) nb = TB;
    else                   nb = first_nz(p) + RL;
    return 2 * CD * (8 * (1 + nb) + 1);
  endfunction

  task automatic model(input logic [7:0] c, input plan_t p);
    exp_t e;
    int   f;
    if (!c[7]) return;
    if (times_out(p)) begin
      e.is_to = 1'b1;
      e.d     = 8'h00;
      exp_q.push_back(e);
      return;
    end
    f = first_nz(p);
    for (int j = 0; j < RL; j++) begin
      e.is_to = 1'b0;
      e.d     = tbyte(p, f + j);
      exp_q.push_back(e);
    end
  endtask

  function automatic plan_t mk_plan(int delay, logic [7:0] r0, logic [7:0] r1);
    plan_t p;
    p.delay  = delay;
    p.silent = 1'b0;
    p.r[0]   = r0;
    p.r[1]   = r1;
    p.r[2]   = 8'hC3;
    p.r[3]   = 8'h3C;
    return p;
  endfunction

  function automatic plan_t rand_plan();
    plan_t p;
    p.delay  = $urandom_range(0, 5);
    p.silent = 1'b0;
    for (int i = 0; i < 4; i++) p.r[i] = 8'($urandom);
    if ($urandom_range(0, 3) == 0) p.r[0] = 8'h00;
    if ($urandom_range(0, 2) == 0) p.r[1] = 8'h00;
    if (p.r[3] == 8'h00) p.r[3] = 8'h5A;
    return p;
  endfunction

  // Target: samples di on rising debug_clk, drives do on rising edges after the command.
  initial begin : target
    plan_t      p;
    int         k, j, bi;
    logic [7:0] rx, b;
    debug_do = 1'b0;
    led      = 1'b0;
    forever begin
      @(posedge debug_cs);
      if (plan_q.size() != 0) p = plan_q.pop_front();
      else p = '{delay: 0, r: '0, silent: 1'b1};
      last_rx = 8'hxx;
      rx      = 8'h00;
      k       = 0;
      while (debug_cs) begin
        @(posedge debug_clk or negedge debug_cs);
        if (!debug_cs) break;
        if (k == 0) t_rise0 = $time;
        if (k == 1) t_rise1 = $time;
        if (k < 8) rx = {rx[6:0], debug_di};
        if (k == 7) begin
          last_rx = rx;
          if (rx == 8'h80 || rx == 8'h81) led = rx[0];
        end
        if (k >= 8) begin
          j        = (k - 8) / 8;
          bi       = 7 - ((k - 8) % 8);
          b        = tbyte(p, j);
          debug_do = b[bi];
        end
        k++;
      end
      debug_do = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (bus.resp_valid || bus.resp_timeout) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_resp: got valid=%0b timeout=%0b data=%02h, required no output",
                 bus.resp_valid, bus.resp_timeout, bus.resp_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_timeout", 32'(bus.resp_timeout), 32'(mon_e.is_to));
        chk("resp_valid", 32'(bus.resp_valid), 32'(!mon_e.is_to));
        if (!mon_e.is_to) chk("resp_data", 32'(bus.resp_data), 32'(mon_e.d));
      end
    end
  end

  task automatic issue(input logic [7:0] c, input plan_t p, input bit push);
    int n;
    plan_q.push_back(p);
    if (push) model(c, p);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = c;
    n = 0;
    while (!bus.cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_at_issue", 32'(bus.cmd_ready), 1);
    @(posedge clk);
    acc_t = $time;
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'($urandom);
  endtask

  task automatic finish_txn(input logic [7:0] c, input plan_t p, input bit timing);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.cmd_ready && n < 5000);
    chk("txn_cycles", 32'(n), 32'(dur(c, p)));
    chk("drain", 32'(exp_q.size()), 0);
    chk("cmd_bits", 32'(last_rx), 32'(c));
    chk("idle_pins", 32'({debug_cs, debug_clk, debug_di}), 0);
    if (c[7:1] == 7'h40) chk("led", 32'(led), 32'(c[0]));
    if (timing) begin
      chk("first_rise", 32'(int'((t_rise0 - acc_t) / T)), 32'(CD));
      chk("bit_period", 32'(int'((t_rise1 - t_rise0) / T)), 32'(2 * CD));
    end
    exp_q.delete();
  endtask

  initial begin : watchdog
    #(60000 * T);
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin : stim
    plan_t      p;
    plan_t      hp[3];
    logic [7:0] c;
    time        at[3];
    int         k, nn;

    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 0);
    chk("rst_resp_timeout", 32'(bus.resp_timeout), 0);
    chk("rst_resp_data", 32'(bus.resp_data), 0);
    chk("rst_debug_cs", 32'(debug_cs), 0);
    chk("rst_debug_clk", 32'(debug_clk), 0);
    chk("rst_debug_di", 32'(debug_di), 0);
    rst = 1'b0;

    // LED on, reply after three zero bytes.
    p = mk_plan(3, 8'h01, 8'h00);
    issue(8'h81, p, 1'b1);
    finish_txn(8'h81, p, 1'b1);

    // LED off.
    p = mk_plan(1, 8'h01, 8'h00);
    issue(8'h80, p, 1'b1);
    finish_txn(8'h80, p, 1'b1);

    // No-response command.
    p = mk_plan(0, 8'h33, 8'h44);
    issue(8'h05, p, 1'b1);
    finish_txn(8'h05, p, 1'b1);

    // Reset during the fifth command bit.
    p = mk_plan(0, 8'h77, 8'h66);
    issue(8'h81, p, 1'b0);
    repeat (8 * CD + 1) @(posedge clk);
    chk("cs_before_abort", 32'(debug_cs), 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_cs", 32'(debug_cs), 0);
    chk("abort_clk", 32'(debug_clk), 0);
    chk("abort_ready", 32'(bus.cmd_ready), 1);
    @(negedge clk);
    p = mk_plan(2, 8'h01, 8'h00);
    plan_q.push_back(p);
    model(8'h81, p);
    rst           = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = 8'h81;
    chk("ready_after_rst", 32'(bus.cmd_ready), 1);
    @(posedge clk);
    acc_t = $time;
    #1;
    bus.cmd_valid = 1'b0;
    chk("first_edge_accept", 32'(debug_cs), 1);
    finish_txn(8'h81, p, 1'b1);

    // cmd_valid held high across three transactions.
    for (int i = 0; i < 3; i++) begin
      hp[i] = rand_plan();
      plan_q.push_back(hp[i]);
      model(8'h81, hp[i]);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = 8'h81;
    k  = 0;
    nn = 0;
    while (k < 3 && nn < 20000) begin
      if (bus.cmd_ready) begin
        at[k] = $time + T / 2;
        k++;
      end
      if (k < 3) begin
        @(negedge clk);
        nn++;
      end
    end
    @(posedge clk);
    acc_t = $time;
    #1;
    bus.cmd_valid = 1'b0;
    chk("held_accepts", 32'(k), 3);
    if (k == 3) begin
      chk("held_spacing0", 32'(int'((at[1] - at[0]) / T)), 32'(dur(8'h81, hp[0]) + 1));
      chk("held_spacing1", 32'(int'((at[2] - at[1]) / T)), 32'(dur(8'h81, hp[1]) + 1));
    end
    finish_txn(8'h81, hp[2], 1'b1);

    // Randomised commands and target replies.
    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 3))
        0:       c = 8'h80;
        1:       c = 8'h81;
        2:       c = 8'($urandom) & 8'h7F;
        default: c = 8'($urandom) | 8'h80;
      endcase
      p = rand_plan();
      issue(c, p, 1'b1);
      finish_txn(c, p, 1'b1);
    end

`ifdef DEBUG_MASTER_TIMEOUT_EN
    // Silent target.
    p        = mk_plan(0, 8'h00, 8'h00);
    p.silent = 1'b1;
    issue(8'h81, p, 1'b1);
    finish_txn(8'h81, p, 1'b1);
`endif

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_master.md
DEBUG_MASTER -- requirements
Module: debug_master

Interface
REQ-001 Parameter ClkDiv, default 2: clk cycles per debug_clk half-period, legal range 1..255.
REQ-002 Parameter RespLen, default 2: response bytes per command, legal range 1..16.
REQ-003 Parameter TimeoutBytes, default 16: filler bytes shifted before the block reports a timeout.
REQ-004 Port clk, input, 1: sole clock; all state SHALL change on posedge clk.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port cmd_valid, input, 1: cmd_data is valid.
REQ-007 Port cmd_data, input, 8: command byte to send (0x80 = LED off, 0x81 = LED on).
REQ-008 Port cmd_ready, output, 1: block is IDLE and will accept a command.
REQ-009 Port resp_valid, output, 1: one-cycle pulse; resp_data holds one response byte.
REQ-010 Port resp_data, output, 8: response byte, MSB-first order as received.
REQ-011 Port resp_timeout, output, 1: one-cycle pulse when no response arrives.
REQ-012 Port debug_clk, output, 1: serial clock to the target.
REQ-013 Port debug_cs, output, 1: active-high select to the target.
REQ-014 Port debug_di, output, 1: serial data to the target.
REQ-015 Port debug_do, input, 1: serial data from the target.

Function
REQ-016 A command SHALL be accepted only on a cycle where cmd_valid and cmd_ready are both high; cmd_data SHALL be latched on that cycle.
REQ-017 Bit timing: debug_clk SHALL toggle every ClkDiv clk cycles while a transaction runs and SHALL idle low; bit period = 2*ClkDiv clk cycles.
REQ-018 debug_di SHALL change only on debug_clk falling edges, or before the first rising edge; debug_do SHALL be sampled at each debug_clk falling edge.
REQ-019 State machine IDLE -> CMD -> WAIT -> RESP -> GAP -> IDLE; a timeout SHALL exit WAIT -> GAP.
REQ-020 IDLE: cmd_ready=1, debug_cs=0, debug_clk=0, debug_di=0.
REQ-021 Acceptance: debug_cs SHALL rise in the acceptance cycle; debug_di SHALL present cmd_data[7] one half-period before the first rising edge.
REQ-022 CMD: the block SHALL shift 8 bits MSB first, then enter WAIT.
REQ-023 If cmd_data[7]=0, the block SHALL shift the command and go CMD -> GAP with no response and no timeout.
REQ-024 WAIT/RESP: debug_di SHALL be held 0 (Nop filler).
REQ-025 WAIT/RESP: debug_do bits SHALL be grouped into bytes on 8-bit boundaries counted from the first falling edge after CMD completes.
REQ-026 WAIT: the first nonzero byte SHALL be emitted as a response byte, and the block SHALL go to RESP.
REQ-027 RESP: the next RespLen-1 bytes SHALL be emitted unconditionally, including zero bytes, then the block SHALL go to GAP.
REQ-028 resp_valid SHALL pulse exactly one clk cycle after the falling edge that samples each byte's LSB; there is no backpressure.
REQ-029 GAP: debug_cs=0 and debug_clk=0 for 2*ClkDiv clk cycles, then IDLE.
REQ-030 cmd_valid asserted outside IDLE SHALL be ignored, with no queuing.
REQ-031 Byte and bit counters SHALL saturate-free wrap only via state exit; the timeout counter SHALL be 8 bits wide.

Reset
REQ-032 While rst=1, the block SHALL be in IDLE and every output SHALL be 0, except cmd_ready=1.
REQ-033 rst asserted mid-transaction SHALL abort it immediately: debug_cs=0 and debug_clk=0 asynchronously, with no resp_valid or resp_timeout pulse.
REQ-034 After rst deasserts, the first command SHALL be acceptable on the first posedge clk.

Configuration
REQ-035 Macro DEBUG_MASTER_TIMEOUT_EN defined: after TimeoutBytes all-zero filler bytes in WAIT, the block SHALL pulse resp_timeout and go to GAP.
REQ-036 Macro DEBUG_MASTER_TIMEOUT_EN undefined: WAIT SHALL persist until a nonzero byte arrives or reset; resp_timeout SHALL be constant 0.

Verification
REQ-037 Scenario: ClkDiv=2, send 0x81; the target model replies 0x01,0x00 after 3 zero bytes -> di bit sequence 1,0,0,0,0,0,0,1 with a 4-clk bit period; resp_valid pulses twice with resp_data 0x01 then 0x00.
REQ-038 Scenario: send 0x80, the target replies 0x01,0x00 -> LED model reads 0 and the response is 0x01,0x00; cmd_ready returns high after GAP.
REQ-039 Scenario: DEBUG_MASTER_TIMEOUT_EN defined, TimeoutBytes=4, target silent -> resp_timeout pulses once after 4 filler bytes (128 clk at ClkDiv=2) and no resp_valid pulses.
REQ-040 Scenario: send 0x05 -> 8 bits shifted, GAP entered directly, no resp_valid or resp_timeout pulses.
REQ-041 Scenario: rst asserted during the 5th command bit -> debug_cs and debug_clk are 0 the same cycle, cmd_ready=1 after release, and the next command 0x81 completes normally.
REQ-042 Scenario: cmd_valid held high throughout -> exactly one command accepted per transaction, with acceptances separated by at least the full CMD+WAIT+RESP+GAP duration.
